// File: rtl/sbinit_sb_arbiter.sv
// -----------------------------------------------------------------------------
// sbinit_sb_arbiter
//
// SBINIT stage controller. It sequences the TX_SBINIT and RX_SBINIT halves and
// shares one sideband message encoder between them. Valid-qualified requests
// from both halves are arbitrated round-robin (TX favoured after reset). The
// winning code goes to the encoder until i_SB_ack. The winner then gets a
// one-cycle deassert pulse. Sticky end flags from both halves drive the
// stage-done level.
//
// Optional feature macro: SBINIT_TIMEOUT_EN
//   defined   -> a saturating cycle counter runs in ARB/SEND/RELEASE, and the
//                block enters TIMEOUT after TIMEOUT_CYCLES cycles without DONE.
//   undefined -> no counter, no TIMEOUT entry, o_timeout tied to 0.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_SBINIT_en              stage enable; low returns to IDLE on next edge
//   i_valid_tx/_rx           request from TX/RX half
//   i_encoded_SB_msg_tx/_rx  message code from TX/RX half
//   i_SBINIT_end_tx/_rx      TX/RX half finished
//   i_SB_ack                 encoder finished sending the presented message
//   o_valid                  message presented to encoder
//   o_encoded_SB_msg         presented message code
//   o_deassert_valid_tx/_rx  one-cycle "message sent" pulse to the winner
//   o_SBINIT_end             both halves finished (level)
//   o_timeout                stage timed out (level)
// -----------------------------------------------------------------------------
module sbinit_sb_arbiter #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_SBINIT_en,
  input  logic                    i_valid_tx,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg_tx,
  input  logic                    i_SBINIT_end_tx,
  input  logic                    i_valid_rx,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg_rx,
  input  logic                    i_SBINIT_end_rx,
  input  logic                    i_SB_ack,
  output logic                    o_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
  output logic                    o_deassert_valid_tx,
  output logic                    o_deassert_valid_rx,
  output logic                    o_SBINIT_end,
  output logic                    o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_SEND    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_e;

  state_e                  state_q;
  logic                    ptr_rx_q;    // 1: RX wins the next contention
  logic                    grant_rx_q;  // identity of the in-flight winner
  logic                    end_tx_q;
  logic                    end_rx_q;
  logic                    valid_q;
  logic [SB_MSG_WIDTH-1:0] msg_q;
  logic                    dtx_q;
  logic                    drx_q;
  logic                    sbinit_end_q;

  logic pick_tx_s;
  logic pick_rx_s;
  logic both_end_s;

  // Round-robin pick: a lone requester always wins; on contention the pointer decides.
  assign pick_tx_s  = i_valid_tx & (~i_valid_rx | ~ptr_rx_q);
  assign pick_rx_s  = i_valid_rx & ~pick_tx_s;
  assign both_end_s = end_tx_q & end_rx_q;

`ifdef SBINIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             tmo_hit_s;
  logic             active_s;

  assign active_s  = (state_q == S_ARB) | (state_q == S_SEND) | (state_q == S_RELEASE);
  assign tmo_hit_s = active_s & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturating stage-time counter; only counts while the stage is in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (!i_SBINIT_en || state_q == S_IDLE) begin
      cnt_q <= '0;
    end else if (active_s && cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Stage FSM with registered outputs, sticky end flags and arbitration pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      ptr_rx_q     <= 1'b0;
      grant_rx_q   <= 1'b0;
      end_tx_q     <= 1'b0;
      end_rx_q     <= 1'b0;
      valid_q      <= 1'b0;
      msg_q        <= '0;
      dtx_q        <= 1'b0;
      drx_q        <= 1'b0;
      sbinit_end_q <= 1'b0;
`ifdef SBINIT_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else if (!i_SBINIT_en) begin
      // Enable drop beats everything, including a same-cycle ack; pointer is kept.
      state_q      <= S_IDLE;
      grant_rx_q   <= 1'b0;
      end_tx_q     <= 1'b0;
      end_rx_q     <= 1'b0;
      valid_q      <= 1'b0;
      msg_q        <= '0;
      dtx_q        <= 1'b0;
      drx_q        <= 1'b0;
      sbinit_end_q <= 1'b0;
`ifdef SBINIT_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      dtx_q <= 1'b0;
      drx_q <= 1'b0;
      if (state_q != S_IDLE) begin
        end_tx_q <= end_tx_q | i_SBINIT_end_tx;
        end_rx_q <= end_rx_q | i_SBINIT_end_rx;
      end

      case (state_q)
        S_IDLE: begin
          state_q <= S_ARB;
        end
        S_ARB: begin
          // DONE is only taken here, so an in-flight message always completes first.
          if (both_end_s) begin
            state_q      <= S_DONE;
            sbinit_end_q <= 1'b1;
          end else if (pick_tx_s || pick_rx_s) begin
            state_q    <= S_SEND;
            grant_rx_q <= pick_rx_s;
            ptr_rx_q   <= pick_tx_s;
            valid_q    <= 1'b1;
            msg_q      <= pick_rx_s ? i_encoded_SB_msg_rx : i_encoded_SB_msg_tx;
          end else begin
            state_q <= S_ARB;
          end
        end
        S_SEND: begin
          if (i_SB_ack) begin
            state_q <= S_RELEASE;
            valid_q <= 1'b0;
            msg_q   <= '0;
            dtx_q   <= ~grant_rx_q;
            drx_q   <= grant_rx_q;
          end else begin
            state_q <= S_SEND;
          end
        end
        S_RELEASE: begin
          state_q    <= S_ARB;
          grant_rx_q <= 1'b0;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        S_TIMEOUT: begin
          state_q <= S_TIMEOUT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

`ifdef SBINIT_TIMEOUT_EN
      // Expiry overrides the case above unless DONE is being taken this cycle.
      if (tmo_hit_s && !(state_q == S_ARB && both_end_s)) begin
        state_q    <= S_TIMEOUT;
        valid_q    <= 1'b0;
        msg_q      <= '0;
        dtx_q      <= 1'b0;
        drx_q      <= 1'b0;
        grant_rx_q <= 1'b0;
        timeout_q  <= 1'b1;
      end
`endif
    end
  end

  assign o_valid             = valid_q;
  assign o_encoded_SB_msg    = msg_q;
  assign o_deassert_valid_tx = dtx_q;
  assign o_deassert_valid_rx = drx_q;
  assign o_SBINIT_end        = sbinit_end_q;

endmodule

// File: tb/tb_sbinit_sb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for sbinit_sb_arbiter. A behavioural model of the stage (enable,
// outstanding message, release pulse, elapsed active cycles, sticky flags)
// predicts every output and is compared on each falling edge. Directed
// scenarios add hand-computed literal checks at fixed cycle offsets.
// -----------------------------------------------------------------------------
module tb_sbinit_sb_arbiter;

  localparam int W  = 4;
  localparam int TC = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         vtx = 1'b0, vrx = 1'b0, etx = 1'b0, erx = 1'b0, ack = 1'b0;
  logic [W-1:0] mtx = '0, mrx = '0;

  logic         o_valid, o_dtx, o_drx, o_end, o_to;
  logic [W-1:0] o_msg;

  int errors = 0;
  int checks = 0;

  sbinit_sb_arbiter #(.SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(TC)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_SBINIT_en         (en),
    .i_valid_tx          (vtx),
    .i_encoded_SB_msg_tx (mtx),
    .i_SBINIT_end_tx     (etx),
    .i_valid_rx          (vrx),
    .i_encoded_SB_msg_rx (mrx),
    .i_SBINIT_end_rx     (erx),
    .i_SB_ack            (ack),
    .o_valid             (o_valid),
    .o_encoded_SB_msg    (o_msg),
    .o_deassert_valid_tx (o_dtx),
    .o_deassert_valid_rx (o_drx),
    .o_SBINIT_end        (o_end),
    .o_timeout           (o_to)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit         m_on, m_done, m_tmo, m_ftx, m_frx, m_favour_rx;
  int         m_busy;     // -1: no message at encoder, 0: TX's, 1: RX's
  bit         m_rel;      // release cycle in progress
  int         m_since;    // edges elapsed since the stage became active
  bit         e_valid, e_dtx, e_drx, e_end, e_to;
  logic [W-1:0] e_msg;

  task automatic m_clear_outputs();
    e_valid = 1'b0; e_dtx = 1'b0; e_drx = 1'b0; e_end = 1'b0; e_to = 1'b0; e_msg = '0;
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int  side;
    bit  took_done;
    if (!rst_n) begin
      m_on = 0; m_done = 0; m_tmo = 0; m_ftx = 0; m_frx = 0; m_favour_rx = 0;
      m_busy = -1; m_rel = 0; m_since = 0;
      m_clear_outputs();
    end else if (!en) begin
      m_on = 0; m_done = 0; m_tmo = 0; m_ftx = 0; m_frx = 0;
      m_busy = -1; m_rel = 0; m_since = 0;
      m_clear_outputs();
    end else if (!m_on) begin
      m_on = 1; m_since = 0;
    end else if (m_done || m_tmo) begin
      m_ftx = m_ftx | etx; m_frx = m_frx | erx;
    end else begin
      took_done = 0;
      m_since++;
      e_dtx = 0; e_drx = 0;
      if (m_rel) begin
        m_rel = 0;
      end else if (m_busy != -1) begin
        if (ack) begin
          e_dtx = (m_busy == 0); e_drx = (m_busy == 1);
          m_busy = -1; m_rel = 1; e_valid = 0; e_msg = '0;
        end
      end else if (m_ftx && m_frx) begin
        m_done = 1; e_end = 1; took_done = 1;
      end else if (vtx || vrx) begin
        if (vtx && vrx) side = m_favour_rx ? 1 : 0;
        else            side = vtx ? 0 : 1;
        m_busy = side; m_favour_rx = (side == 0);
        e_valid = 1; e_msg = (side == 0) ? mtx : mrx;
      end
`ifdef SBINIT_TIMEOUT_EN
      if (!took_done && m_since == TC) begin
        m_tmo = 1; m_busy = -1; m_rel = 0;
        m_clear_outputs();
        e_to = 1;
      end
`endif
      m_ftx = m_ftx | etx; m_frx = m_frx | erx;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit         cmp_on = 0;
  bit         prev_valid = 0;
  logic [W-1:0] sent[$];

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_valid", o_valid, e_valid);
      chk("m_msg",   o_msg,   e_msg);
      chk("m_dtx",   o_dtx,   e_dtx);
      chk("m_drx",   o_drx,   e_drx);
      chk("m_end",   o_end,   e_end);
      chk("m_to",    o_to,    e_to);
      if (o_valid && !prev_valid) sent.push_back(o_msg);
      prev_valid = o_valid;
    end
  end

  // Requester + encoder behaviour: ack whatever is presented, drop valid on pulse.
  task automatic serve(input int budget, input string name);
    int n;
    n = 0;
    while ((vtx || vrx) && n < budget) begin
      tick();
      ack = o_valid;
      if (o_dtx) vtx = 1'b0;
      if (o_drx) vrx = 1'b0;
      n++;
    end
    ack = 1'b0;
    if (vtx || vrx) begin
      chk({name, "_budget"}, 32'd0, 32'd1);
      vtx = 1'b0; vrx = 1'b0;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    @(posedge clk);
    cmp_on = 1;
    tick(); tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_end", o_end, 0);
    chk("rst_to", o_to, 0);
    rst_n = 1'b1;
    tick();

    // T1: single TX send, ack three cycles after the request
    en = 1'b1;                 // cycle 0
    tick(); tick();            // edge 2
    vtx = 1'b1; mtx = 4'd2;
    tick();                    // edge 3: SEND
    chk("t1_valid3", o_valid, 1);
    chk("t1_msg3", o_msg, 2);
    tick(); tick();            // edge 5
    chk("t1_msg5", o_msg, 2);
    ack = 1'b1;
    tick();                    // edge 6: release
    chk("t1_valid6", o_valid, 0);
    chk("t1_dtx6", o_dtx, 1);
    chk("t1_drx6", o_drx, 0);
    ack = 1'b0; vtx = 1'b0;
    tick();
    chk("t1_dtx7", o_dtx, 0);
    chk("t1_sent", sent.size(), 1);

    // T2: contention from reset, pointer retained across an enable drop
    en = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    sent.delete();
    en = 1'b1;
    tick();
    vtx = 1'b1; mtx = 4'd1; vrx = 1'b1; mrx = 4'd3;
    serve(40, "t2a");
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    vtx = 1'b1; mtx = 4'd5; vrx = 1'b1; mrx = 4'd6;
    serve(40, "t2b");
    tick();
    chk("t2_count", sent.size(), 4);
    if (sent.size() == 4) begin
      chk("t2_first", sent[0], 1);
      chk("t2_second", sent[1], 3);
      chk("t2_third", sent[2], 5);
      chk("t2_fourth", sent[3], 6);
    end

    // T3: end flags at cycles 5 and 9 -> stage done at cycle 11
    en = 1'b0;
    tick();
    en = 1'b1;                 // cycle 0
    repeat (5) tick();
    etx = 1'b1;                // cycle 5
    repeat (4) tick();
    erx = 1'b1;                // cycle 9
    tick();
    chk("t3_end10", o_end, 0);
    tick();
    chk("t3_end11", o_end, 1);
    tick();
    chk("t3_end12", o_end, 1);
    en = 1'b0; etx = 1'b0; erx = 1'b0;
    tick();
    chk("t3_end_off", o_end, 0);

    // T4a: both ends raised during SEND -> RELEASE, ARB, then DONE
    en = 1'b1;
    tick();
    vrx = 1'b1; mrx = 4'd7;
    tick();
    chk("t4a_valid", o_valid, 1);
    chk("t4a_msg", o_msg, 7);
    etx = 1'b1; erx = 1'b1;
    tick(); tick();
    chk("t4a_hold", o_valid, 1);
    ack = 1'b1;
    tick();
    chk("t4a_drx", o_drx, 1);
    chk("t4a_dtx", o_dtx, 0);
    chk("t4a_end_rel", o_end, 0);
    ack = 1'b0; vrx = 1'b0; etx = 1'b0; erx = 1'b0;
    tick();
    chk("t4a_end_arb", o_end, 0);
    tick();
    chk("t4a_end_done", o_end, 1);

    // T4b: enable drop together with ack in SEND
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    vtx = 1'b1; mtx = 4'd4;
    tick();
    chk("t4b_valid", o_valid, 1);
    etx = 1'b1; erx = 1'b1;
    tick();
    en = 1'b0; ack = 1'b1;
    tick();
    chk("t4b_valid_off", o_valid, 0);
    chk("t4b_no_dtx", o_dtx, 0);
    ack = 1'b0; vtx = 1'b0; etx = 1'b0; erx = 1'b0;
    en = 1'b1;
    repeat (4) tick();
    chk("t4b_end_clear", o_end, 0);

    // T6: stray acks in ARB and IDLE do nothing
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t6_arb_valid", o_valid, 0);
    chk("t6_arb_dtx", o_dtx, 0);
    en = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t6_idle_drx", o_drx, 0);
    en = 1'b1;
    tick();
    vtx = 1'b1; mtx = 4'd9;
    tick();
    chk("t6_send_valid", o_valid, 1);
    chk("t6_send_msg", o_msg, 9);
    serve(10, "t6");

    // T5: timeout (TC=20) or its absence
    en = 1'b0;
    tick();
    en = 1'b1;                 // cycle 0
    repeat (20) tick();
    chk("t5_to20", o_to, 0);
    tick();
`ifdef SBINIT_TIMEOUT_EN
    chk("t5_to21", o_to, 1);
    repeat (5) tick();
    chk("t5_to_held", o_to, 1);
`else
    chk("t5_to21", o_to, 0);
    repeat (5) tick();
    chk("t5_to_held", o_to, 0);
`endif
    en = 1'b0;
    tick();
    chk("t5_to_off", o_to, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
